// File: rtl/cache_types.sv
// Shared cache type definitions: adaptor FSM state encoding and burst geometry.
package cache_types;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } adaptor_state_t;

    localparam int          BEATS          = 4;
    localparam int          BURST_WIDTH    = 64;
    localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFFFFE0;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache line <-> 4-beat DRAM burst adaptor: reads gather beats into a line, writes split a line into beats.
// Optional per-direction completion counters are enabled by defining CACHELINE_ADAPTOR_PERF_CNT_EN.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    output logic [31:0]            rd_count_o,
    output logic [31:0]            wr_count_o,
`endif
    input  logic                   resp_i
);
    import cache_types::adaptor_state_t, cache_types::IDLE, cache_types::RD_BURST,
           cache_types::RD_DONE, cache_types::WR_BURST, cache_types::WR_DONE,
           cache_types::BEATS, cache_types::LINE_ADDR_MASK;

    localparam int             CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adaptor_state_t        state;
    logic [CNT_W-1:0]      cnt;
    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] buf_q;

    function automatic logic [BURST_WIDTH-1:0] get_beat(input logic [LINE_WIDTH-1:0] l,
                                                        input logic [CNT_W-1:0]      idx);
        return l[idx*BURST_WIDTH +: BURST_WIDTH];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_q    <= '0;
            buf_q     <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_o <= 1'b0;
                    cnt    <= '0;
                    // Read has priority when the cache raises both requests.
                    if (read_i) begin
                        address_o <= address_i & ADDR_WIDTH'(LINE_ADDR_MASK);
                        read_o    <= 1'b1;
                        state     <= RD_BURST;
                    end else if (write_i) begin
                        address_o <= address_i & ADDR_WIDTH'(LINE_ADDR_MASK);
                        line_q    <= line_i;
                        burst_o   <= line_i[BURST_WIDTH-1:0];
                        write_o   <= 1'b1;
                        state     <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        buf_q[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            // Final beat goes straight into line_o so it is valid alongside resp_o.
                            line_o <= {burst_i, buf_q[LINE_WIDTH-BURST_WIDTH-1:0]};
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= WR_DONE;
                        end else begin
                            burst_o <= get_beat(line_q, cnt + 1'b1);
                        end
                    end
                end
                WR_DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            if (state == RD_DONE) rd_count_o <= sat_inc(rd_count_o);
            if (state == WR_DONE) wr_count_o <= sat_inc(wr_count_o);
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed vector table, reset corner cases, random transactions.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    logic [31:0]  rd_count_o;
    logic [31:0]  wr_count_o;
`endif

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
        .rd_count_o(rd_count_o),
        .wr_count_o(wr_count_o),
`endif
        .resp_i    (resp_i)
    );

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [255:0] last_line;
    int           rd_done = 0;
    int           wr_done = 0;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] line;
        logic [63:0]  b0, b1, b2, b3;
        logic [15:0]  pat;   // resp_i per cycle, LSB first; 1s continue past bit 15
    } vec_t;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] exp_addr, input logic [255:0] line,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3,
                           input logic [15:0] pat, input string tag);
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        logic [2:0]   busy;
        bit           r;
        int           k;
        int           cyc;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        exp_line = '0;
        for (int i = 0; i < 4; i++) exp_line = exp_line | ({192'b0, b[i]} << (64 * i));
        busy = rd ? 3'b100 : 3'b010;

        address_i = addr; line_i = line; read_i = rd; write_i = wr;
        resp_i = 1'b0; burst_i = '0;
        @(posedge clk); @(negedge clk);
        chk({tag, ".addr"}, 256'(address_o), 256'(exp_addr));

        k = 0; cyc = 0;
        while (k < 4 && cyc < 64) begin
            r = (cyc < 16) ? pat[cyc] : 1'b1;
            resp_i  = r;
            burst_i = r ? b[k] : 64'hDEAD_BEEF_0BAD_F00D;
            chk({tag, ".busy"}, 256'({read_o, write_o, resp_o}), 256'(busy));
            if (!rd) chk({tag, ".burst_o"}, 256'(burst_o), 256'(64'(line >> (64 * k))));
            @(posedge clk); @(negedge clk);
            if (r) k++;
            cyc++;
        end
        if (k < 4) begin
            n_chk++; n_fail++;
            $display("FAIL %s.timeout: got %0d beats expected 4", tag, k);
        end
        resp_i = 1'b0;
        chk({tag, ".done"}, 256'({read_o, write_o, resp_o}), 256'(3'b001));
        if (rd) begin
            last_line = exp_line;
            rd_done++;
        end else begin
            wr_done++;
        end
        chk({tag, ".line_o"}, line_o, last_line);
        read_i = 1'b0; write_i = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, ".idle"}, 256'({read_o, write_o, resp_o}), 256'(3'b000));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         vecs [5];
        logic [31:0]  a;
        logic [255:0] l;
        bit           rd, wr;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, 256'h0,
                    64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 16'hFFFF};
        vecs[1] = '{1'b0, 1'b1, 32'h8000_00FF, 32'h8000_00E0,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    64'h0, 64'h0, 64'h0, 64'h0, 16'hFFFF};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040, 256'h0,
                    64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0, 16'h0059};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_003F, 32'h0000_0020,
                    {4{64'hBAD0_BAD0_BAD0_BAD0}},
                    64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
                    64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4, 16'hFFFF};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                    {64'h4000_0000_0000_0004, 64'h3000_0000_0000_0003,
                     64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001},
                    64'h0, 64'h0, 64'h0, 64'h0, 16'h00A5};

        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0; last_line = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.ctrl", 256'({read_o, write_o, resp_o}), 256'(3'b000));
        chk("reset.address_o", 256'(address_o), 256'(0));
        chk("reset.burst_o", 256'(burst_o), 256'(0));
        chk("reset.line_o", line_o, 256'(0));
        rst = 1'b0;

        // Stray memory responses while idle must not start anything.
        resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("idle.resp_ignored", 256'({read_o, write_o, resp_o}), 256'(3'b000));
        end
        resp_i = 1'b0;

        for (int i = 0; i < 5; i++)
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].exp_addr, vecs[i].line,
                    vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].pat,
                    $sformatf("vec%0d", i));

        // Reset after two beats of a read: partial line is dropped.
        address_i = 32'h0000_5000; read_i = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
        @(posedge clk); @(negedge clk);
        burst_i = 64'h8888_8888_8888_8888;
        @(posedge clk); @(negedge clk);
        rst = 1'b1; resp_i = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst.ctrl", 256'({read_o, write_o, resp_o}), 256'(3'b000));
        chk("midrst.line_o", line_o, 256'(0));
        chk("midrst.address_o", 256'(address_o), 256'(0));
        rst = 1'b0; read_i = 1'b0; last_line = '0; rd_done = 0; wr_done = 0;
        @(posedge clk); @(negedge clk);
        run_txn(1'b1, 1'b0, 32'h0000_6008, 32'h0000_6000, 256'h0,
                64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00B1,
                64'h0000_0000_0000_00C2, 64'h0000_0000_0000_00D3, 16'hFFFF, "postrst");

        for (int i = 0; i < 20; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            a  = $urandom;
            l  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn(rd, wr, a, (a / 32) * 32, l,
                    {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom},
                    16'($urandom), $sformatf("rnd%0d", i));
        end

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
        chk("perf.rd_count", 256'(rd_count_o), 256'(rd_done));
        chk("perf.wr_count", 256'(wr_count_o), 256'(wr_done));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
